// File: rtl/cpu_pkg.sv
// Shared types for the two-stage cpu_pipe datapath: ALU opcodes, operand-mux
// encodings and the control part of the S1/S2 pipeline registers.
package cpu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  localparam logic MUX0_REG_B = 1'b0;
  localparam logic MUX0_IMM   = 1'b1;
  localparam logic MUX1_REG_A = 1'b0;
  localparam logic MUX1_ZERO  = 1'b1;
  localparam logic MUX2_ALU   = 1'b0;
  localparam logic MUX2_MOVE  = 1'b1;

  // Data/address fields are width-parametrised and live beside these structs.
  typedef struct packed {
    logic    valid;
    logic    we;
    logic    mux_1_sel;
    logic    mux_2_sel;
    alu_op_e op;
  } s1_ctrl_t;

  typedef struct packed {
    logic valid;
    logic we;
  } s2_ctrl_t;

  function automatic logic uses_a(input logic mux_1_sel, input logic mux_2_sel);
    return (mux_1_sel == MUX1_REG_A) || (mux_2_sel == MUX2_MOVE);
  endfunction

  function automatic logic uses_b(input logic mux_0_sel);
    return mux_0_sel == MUX0_REG_B;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for cpu_pipe; shifts use the low clog2(WORDSIZE) bits of b.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input  alu_op_e             op_i,
  input  logic [WORDSIZE-1:0] a_i,
  input  logic [WORDSIZE-1:0] b_i,
  output logic [WORDSIZE-1:0] y_o
);

  localparam int SW = $clog2(WORDSIZE);

  logic [SW-1:0] shamt;
  logic          lt;

  assign shamt = b_i[SW-1:0];
  assign lt    = $signed(a_i) < $signed(b_i);

  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_XOR: y_o = a_i ^ b_i;
      ALU_SLL: y_o = a_i << shamt;
      ALU_SRL: y_o = a_i >> shamt;
      ALU_SLT: y_o = {{(WORDSIZE-1){1'b0}}, lt};
    endcase
  end

endmodule

// File: rtl/cpu_pipe.sv
// Two-stage ALU pipeline with internal register file. Define CPU_FORWARD_EN to
// bypass results from S1/S2 instead of stalling on read-after-write hazards.
module cpu_pipe
  import cpu_pkg::*;
#(
  parameter  int WORDSIZE = 64,
  parameter  int REGCOUNT = 32,
  parameter  int IMMWIDTH = 12,
  localparam int AW       = $clog2(REGCOUNT)
) (
  input  logic                cpu_clk,
  input  logic                cpu_rst_n,
  input  logic                cpu_valid,
  output logic                cpu_ready,
  input  logic [AW-1:0]       cpu_rf_addr_a,
  input  logic [AW-1:0]       cpu_rf_addr_b,
  input  logic [AW-1:0]       cpu_rf_write_addr,
  input  logic                cpu_rf_write_en,
  input  logic [IMMWIDTH-1:0] cpu_immediate,
  input  logic                cpu_mux_0_sel,
  input  logic                cpu_mux_1_sel,
  input  logic                cpu_mux_2_sel,
  input  logic [2:0]          cpu_alu_operation,
  output logic                cpu_res_valid,
  input  logic                cpu_res_ready,
  output logic [WORDSIZE-1:0] cpu_res_data,
  output logic [AW-1:0]       cpu_res_addr,
  output logic                cpu_res_we
);

  // Handshakes: a transfer happens on the rising edge where valid and ready are
  // both high; valid never waits on ready, and held data stays stable.

  logic [WORDSIZE-1:0] rf_q [REGCOUNT];

  s1_ctrl_t            s1_q, s1_d;
  logic [WORDSIZE-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [AW-1:0]       s1_waddr_q, s1_waddr_d;
  s2_ctrl_t            s2_q, s2_d;
  logic [WORDSIZE-1:0] s2_data_q, s2_data_d;
  logic [AW-1:0]       s2_addr_q, s2_addr_d;

  logic                s1_load, s2_load, accept, hazard, rf_wr_fire;
  logic                s1_hit_a, s2_hit_a, s1_hit_b, s2_hit_b;
  logic [WORDSIZE-1:0] rf_a, rf_b, op_a, op_b, imm_sext, alu_a, alu_y, s1_res;

  assign imm_sext   = {{(WORDSIZE-IMMWIDTH){cpu_immediate[IMMWIDTH-1]}}, cpu_immediate};
  assign rf_wr_fire = s2_q.valid && cpu_res_ready && s2_q.we && (s2_addr_q != '0);

  // Register 0 reads as zero; a retiring write is visible to same-cycle reads.
  always_comb begin
    rf_a = rf_q[cpu_rf_addr_a];
    rf_b = rf_q[cpu_rf_addr_b];
    if (rf_wr_fire && (s2_addr_q == cpu_rf_addr_a)) rf_a = s2_data_q;
    if (rf_wr_fire && (s2_addr_q == cpu_rf_addr_b)) rf_b = s2_data_q;
    if (cpu_rf_addr_a == '0) rf_a = '0;
    if (cpu_rf_addr_b == '0) rf_b = '0;
  end

  assign s1_hit_a = (cpu_rf_addr_a != '0) && s1_q.valid && s1_q.we && (s1_waddr_q == cpu_rf_addr_a);
  assign s2_hit_a = (cpu_rf_addr_a != '0) && s2_q.valid && s2_q.we && (s2_addr_q == cpu_rf_addr_a);
  assign s1_hit_b = (cpu_rf_addr_b != '0) && s1_q.valid && s1_q.we && (s1_waddr_q == cpu_rf_addr_b);
  assign s2_hit_b = (cpu_rf_addr_b != '0) && s2_q.valid && s2_q.we && (s2_addr_q == cpu_rf_addr_b);

`ifdef CPU_FORWARD_EN
  always_comb begin
    op_a   = s1_hit_a ? s1_res : (s2_hit_a ? s2_data_q : rf_a);
    op_b   = s1_hit_b ? s1_res : (s2_hit_b ? s2_data_q : rf_b);
    hazard = 1'b0;
  end
`else
  always_comb begin
    op_a   = rf_a;
    op_b   = rf_b;
    hazard = (uses_a(cpu_mux_1_sel, cpu_mux_2_sel) && (s1_hit_a || s2_hit_a)) ||
             (uses_b(cpu_mux_0_sel) && (s1_hit_b || s2_hit_b));
  end
`endif

  assign alu_a  = (s1_q.mux_1_sel == MUX1_ZERO) ? '0 : s1_a_q;
  assign s1_res = (s1_q.mux_2_sel == MUX2_MOVE) ? s1_a_q : alu_y;

  cpu_alu #(.WORDSIZE(WORDSIZE)) u_alu (
    .op_i (s1_q.op),
    .a_i  (alu_a),
    .b_i  (s1_b_q),
    .y_o  (alu_y)
  );

  assign s2_load   = !s2_q.valid || cpu_res_ready;
  assign s1_load   = !s1_q.valid || s2_load;
  assign cpu_ready = cpu_rst_n && s1_load && !hazard;
  assign accept    = cpu_valid && cpu_ready;

  always_comb begin
    s2_d       = s2_q;
    s2_data_d  = s2_data_q;
    s2_addr_d  = s2_addr_q;
    s1_d       = s1_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_waddr_d = s1_waddr_q;
    if (s2_load) begin
      s2_d.valid = s1_q.valid;
      s2_d.we    = s1_q.we;
      s2_addr_d  = s1_waddr_q;
      s2_data_d  = s1_res;
    end
    if (s1_load) begin
      s1_d.valid = accept;
      if (accept) begin
        s1_d.we        = cpu_rf_write_en;
        s1_d.mux_1_sel = cpu_mux_1_sel;
        s1_d.mux_2_sel = cpu_mux_2_sel;
        s1_d.op        = alu_op_e'(cpu_alu_operation);
        s1_a_d         = op_a;
        s1_b_d         = (cpu_mux_0_sel == MUX0_IMM) ? imm_sext : op_b;
        s1_waddr_d     = cpu_rf_write_addr;
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      s1_q       <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_waddr_q <= '0;
      s2_q       <= '0;
      s2_data_q  <= '0;
      s2_addr_q  <= '0;
    end else begin
      s1_q       <= s1_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_waddr_q <= s1_waddr_d;
      s2_q       <= s2_d;
      s2_data_q  <= s2_data_d;
      s2_addr_q  <= s2_addr_d;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      for (int i = 0; i < REGCOUNT; i++) rf_q[i] <= '0;
    end else if (rf_wr_fire) begin
      rf_q[s2_addr_q] <= s2_data_q;
    end
  end

  assign cpu_res_valid = s2_q.valid;
  assign cpu_res_data  = s2_data_q;
  assign cpu_res_addr  = s2_addr_q;
  assign cpu_res_we    = s2_q.we;

endmodule

// File: tb/tb_cpu_pipe.sv
// Bench for cpu_pipe: directed vector table, hand-written pipeline corner cases
// and randomized traffic checked against an in-order architectural model.
module tb_cpu_pipe;

  localparam int W     = 64;
  localparam int AW    = 5;
  localparam int IW    = 12;
  localparam int EXP_W = W + AW + 1;

`ifdef CPU_FORWARD_EN
  localparam int EXP_STALL = 0;
`else
  localparam int EXP_STALL = 2;
`endif

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
                         OP_XOR = 3'd4, OP_SLL = 3'd5, OP_SRL = 3'd6, OP_SLT = 3'd7;

  typedef struct packed {
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [AW-1:0] wa;
    logic          we;
    logic [IW-1:0] imm;
    logic          m0;
    logic          m1;
    logic          m2;
    logic [2:0]    op;
  } instr_t;

  typedef struct {
    instr_t     ins;
    logic [W-1:0] exp_data;
  } vec_t;

  logic          cpu_clk, cpu_rst_n, cpu_valid, cpu_ready;
  logic          cpu_res_valid, cpu_res_ready, cpu_res_we;
  logic [W-1:0]  cpu_res_data;
  logic [AW-1:0] cpu_res_addr;
  instr_t        cur;

  logic [W-1:0]     mregs [32];
  logic [EXP_W-1:0] exp_q[$];
  logic [W-1:0]     ret_q[$];
  logic [W-1:0]     last_data;
  logic [AW-1:0]    last_addr;
  logic             last_we;
  int               n_cmp, n_fail, n_ret;
  logic             bp_en;
  vec_t             tbl [17];

  cpu_pipe dut (
    .cpu_clk           (cpu_clk),
    .cpu_rst_n         (cpu_rst_n),
    .cpu_valid         (cpu_valid),
    .cpu_ready         (cpu_ready),
    .cpu_rf_addr_a     (cur.ra),
    .cpu_rf_addr_b     (cur.rb),
    .cpu_rf_write_addr (cur.wa),
    .cpu_rf_write_en   (cur.we),
    .cpu_immediate     (cur.imm),
    .cpu_mux_0_sel     (cur.m0),
    .cpu_mux_1_sel     (cur.m1),
    .cpu_mux_2_sel     (cur.m2),
    .cpu_alu_operation (cur.op),
    .cpu_res_valid     (cpu_res_valid),
    .cpu_res_ready     (cpu_res_ready),
    .cpu_res_data      (cpu_res_data),
    .cpu_res_addr      (cpu_res_addr),
    .cpu_res_we        (cpu_res_we)
  );

  // ---------------- clock / reset ----------------
  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1000000");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [EXP_W-1:0] act, input logic [EXP_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(input int ra, input int rb, input int wa, input logic we,
                                input logic [IW-1:0] imm, input logic m0, input logic m1,
                                input logic m2, input logic [2:0] op);
    instr_t i;
    i.ra = ra[AW-1:0]; i.rb = rb[AW-1:0]; i.wa = wa[AW-1:0]; i.we = we;
    i.imm = imm; i.m0 = m0; i.m1 = m1; i.m2 = m2; i.op = op;
    return i;
  endfunction

  // Architectural meaning of one instruction against the model register file.
  function automatic logic [W-1:0] ref_result(input instr_t i);
    logic [W-1:0] a, b, x, r;
    a = (i.ra == 0) ? '0 : mregs[i.ra];
    b = i.m0 ? {{(W-IW){i.imm[IW-1]}}, i.imm} : ((i.rb == 0) ? '0 : mregs[i.rb]);
    x = i.m1 ? '0 : a;
    case (i.op)
      OP_ADD:  r = x + b;
      OP_SUB:  r = x - b;
      OP_AND:  r = x & b;
      OP_OR:   r = x | b;
      OP_XOR:  r = x ^ b;
      OP_SLL:  r = x << b[5:0];
      OP_SRL:  r = x >> b[5:0];
      default: r = ($signed(x) < $signed(b)) ? 64'd1 : 64'd0;
    endcase
    return i.m2 ? a : r;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge cpu_clk) begin
    logic [W-1:0] r;
    if (cpu_rst_n) begin
      if (cpu_res_valid && cpu_res_ready) begin
        last_data = cpu_res_data;
        last_addr = cpu_res_addr;
        last_we   = cpu_res_we;
        n_ret++;
        ret_q.push_back(cpu_res_data);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL retire_unexpected: got %h expected none", cpu_res_data);
        end else begin
          check("retire", {cpu_res_we, cpu_res_addr, cpu_res_data}, exp_q.pop_front());
        end
      end
      if (cpu_valid && cpu_ready) begin
        r = ref_result(cur);
        exp_q.push_back({cur.we, cur.wa, r});
        if (cur.we && cur.wa != 0) mregs[cur.wa] = r;
      end
    end
  end

  always @(posedge cpu_clk) begin
    if (bp_en) begin
      #1;
      cpu_res_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- drivers (all input changes happen 1 unit after posedge) ----------------
  task automatic issue(input instr_t ins, output int stalls);
    bit ok;
    ok = 0;
    stalls = 0;
    cur = ins;
    cpu_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge cpu_clk);
      if (cpu_ready) begin
        ok = 1;
        break;
      end
      stalls++;
    end
    check("issue_accept", {69'd0, ok}, 70'd1);
    @(posedge cpu_clk);
    #1;
    cpu_valid = 1'b0;
    cur = '0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    bp_en = 1'b0;
    @(posedge cpu_clk);
    #1;
    cpu_res_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge cpu_clk);
      if (exp_q.size() == 0 && !cpu_res_valid) begin
        done = 1;
        break;
      end
    end
    check("drain", {69'd0, done}, 70'd1);
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic run_one(input string name, input instr_t ins, input logic [W-1:0] exp_data);
    int n0, st;
    n0 = n_ret;
    issue(ins, st);
    for (int n = 0; n < 20 && n_ret == n0; n++) @(negedge cpu_clk);
    check({name, "_retired"}, {69'd0, (n_ret > n0)}, 70'd1);
    check({name, "_data"}, {6'd0, last_data}, {6'd0, exp_data});
    check({name, "_addr"}, {65'd0, last_addr}, {65'd0, ins.wa});
    check({name, "_we"}, {69'd0, last_we}, {69'd0, ins.we});
    @(posedge cpu_clk);
    #1;
  endtask

  // ---------------- test ----------------
  initial begin
    int st, st2, st3;
    n_cmp = 0; n_fail = 0; n_ret = 0;
    bp_en = 1'b0;
    cpu_rst_n = 1'b0;
    cpu_valid = 1'b0;
    cpu_res_ready = 1'b1;
    cur = '0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;

    tbl[0]  = '{mk(0, 0, 5,  1, 12'hFFF, 1, 1, 0, OP_ADD), 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[1]  = '{mk(0, 0, 6,  1, 12'h001, 1, 1, 0, OP_ADD), 64'd1};
    tbl[2]  = '{mk(5, 6, 7,  1, 12'h000, 0, 0, 0, OP_SLT), 64'd1};
    tbl[3]  = '{mk(6, 0, 8,  1, 12'd65,  1, 0, 0, OP_SLL), 64'd2};
    tbl[4]  = '{mk(6, 0, 9,  1, 12'd63,  1, 0, 0, OP_SLL), 64'h8000_0000_0000_0000};
    tbl[5]  = '{mk(9, 0, 10, 1, 12'd63,  1, 0, 0, OP_SRL), 64'd1};
    tbl[6]  = '{mk(6, 5, 11, 1, 12'h000, 0, 0, 0, OP_SUB), 64'd2};
    tbl[7]  = '{mk(5, 0, 12, 1, 12'h0F0, 1, 0, 0, OP_AND), 64'hF0};
    tbl[8]  = '{mk(6, 9, 13, 1, 12'h000, 0, 0, 0, OP_OR),  64'h8000_0000_0000_0001};
    tbl[9]  = '{mk(5, 6, 14, 1, 12'h000, 0, 0, 0, OP_XOR), 64'hFFFF_FFFF_FFFF_FFFE};
    tbl[10] = '{mk(9, 0, 15, 1, 12'h000, 0, 0, 1, OP_ADD), 64'h8000_0000_0000_0000};
    tbl[11] = '{mk(0, 0, 0,  1, 12'h055, 1, 1, 0, OP_ADD), 64'h55};
    tbl[12] = '{mk(0, 0, 16, 1, 12'h000, 0, 0, 1, OP_ADD), 64'd0};
    tbl[13] = '{mk(5, 6, 17, 1, 12'h000, 0, 0, 0, OP_ADD), 64'd0};
    tbl[14] = '{mk(9, 6, 18, 1, 12'h000, 0, 0, 0, OP_SRL), 64'h4000_0000_0000_0000};
    tbl[15] = '{mk(5, 0, 19, 0, 12'hFFF, 1, 0, 0, OP_ADD), 64'hFFFF_FFFF_FFFF_FFFE};
    tbl[16] = '{mk(19, 0, 20, 1, 12'h000, 0, 0, 1, OP_ADD), 64'd0};

    // Reset state
    repeat (3) @(negedge cpu_clk);
    check("rst_ready", {69'd0, cpu_ready}, 70'd0);
    check("rst_res_valid", {69'd0, cpu_res_valid}, 70'd0);
    check("rst_res_data", {6'd0, cpu_res_data}, 70'd0);
    check("rst_res_addr", {65'd0, cpu_res_addr}, 70'd0);
    check("rst_res_we", {69'd0, cpu_res_we}, 70'd0);
    #1 cpu_rst_n = 1'b1;
    #1 check("rel_ready", {69'd0, cpu_ready}, 70'd1);
    @(posedge cpu_clk);
    #1;

    // Two-edge latency of the immediate load
    cur = tbl[0].ins;
    cpu_valid = 1'b1;
    @(negedge cpu_clk);
    check("lat_ready", {69'd0, cpu_ready}, 70'd1);
    @(posedge cpu_clk);
    #1;
    cpu_valid = 1'b0;
    cur = '0;
    @(negedge cpu_clk);
    check("lat_k1_valid", {69'd0, cpu_res_valid}, 70'd0);
    @(negedge cpu_clk);
    check("lat_k2_valid", {69'd0, cpu_res_valid}, 70'd1);
    check("lat_k2_data", {6'd0, cpu_res_data}, {6'd0, 64'hFFFF_FFFF_FFFF_FFFF});
    check("lat_k2_addr", {65'd0, cpu_res_addr}, 70'd5);
    drain();

    // Directed vector table
    for (int i = 0; i < 17; i++) run_one($sformatf("vec%0d", i), tbl[i].ins, tbl[i].exp_data);
    drain();

    // Back-to-back dependency chain
    ret_q.delete();
    issue(mk(0, 0, 1, 1, 12'd7, 1, 1, 0, OP_ADD), st);
    issue(mk(1, 1, 2, 1, 12'd0, 0, 0, 0, OP_ADD), st2);
    issue(mk(2, 1, 3, 1, 12'd0, 0, 0, 0, OP_SUB), st3);
    drain();
    check("dep_stall_x2", st2, EXP_STALL);
    check("dep_stall_x3", st3, EXP_STALL);
    check("dep_count", ret_q.size(), 70'd3);
    check("dep_r0", {6'd0, ret_q[0]}, 70'd7);
    check("dep_r1", {6'd0, ret_q[1]}, 70'd14);
    check("dep_r2", {6'd0, ret_q[2]}, 70'd7);

    // Backpressure with three independent instructions
    ret_q.delete();
    cpu_res_ready = 1'b0;
    issue(mk(0, 0, 20, 1, 12'd100, 1, 1, 0, OP_ADD), st);
    issue(mk(0, 0, 21, 1, 12'd200, 1, 1, 0, OP_ADD), st);
    cur = mk(0, 0, 22, 1, 12'd300, 1, 1, 0, OP_ADD);
    cpu_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge cpu_clk);
      check("bp_ready", {69'd0, cpu_ready}, 70'd0);
      check("bp_valid", {69'd0, cpu_res_valid}, 70'd1);
      check("bp_data", {6'd0, cpu_res_data}, 70'd100);
      check("bp_addr", {65'd0, cpu_res_addr}, 70'd20);
    end
    @(posedge cpu_clk);
    #1 cpu_res_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge cpu_clk);
      if (cpu_ready) break;
    end
    @(posedge cpu_clk);
    #1;
    cpu_valid = 1'b0;
    cur = '0;
    drain();
    check("bp_count", ret_q.size(), 70'd3);
    check("bp_r0", {6'd0, ret_q[0]}, 70'd100);
    check("bp_r1", {6'd0, ret_q[1]}, 70'd200);
    check("bp_r2", {6'd0, ret_q[2]}, 70'd300);

    // Randomized traffic with random result backpressure
    bp_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      issue(mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
               1'($urandom_range(0, 1)), 12'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))), st);
    end
    drain();

    // Reset with S1 and S2 both full
    cpu_res_ready = 1'b0;
    issue(mk(0, 0, 25, 1, 12'd11, 1, 1, 0, OP_ADD), st);
    issue(mk(0, 0, 26, 1, 12'd22, 1, 1, 0, OP_ADD), st);
    #2 cpu_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {69'd0, cpu_res_valid}, 70'd0);
    check("mid_rst_data", {6'd0, cpu_res_data}, 70'd0);
    check("mid_rst_addr", {65'd0, cpu_res_addr}, 70'd0);
    check("mid_rst_we", {69'd0, cpu_res_we}, 70'd0);
    check("mid_rst_ready", {69'd0, cpu_ready}, 70'd0);
    exp_q.delete();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    cpu_res_ready = 1'b1;
    repeat (2) @(negedge cpu_clk);
    #1 cpu_rst_n = 1'b1;
    #1 check("post_rst_ready", {69'd0, cpu_ready}, 70'd1);
    @(posedge cpu_clk);
    #1;
    run_one("post_rst_x25", mk(25, 0, 27, 1, 12'd0, 0, 0, 1, OP_ADD), 64'd0);
    run_one("post_rst_x5", mk(5, 0, 28, 1, 12'd0, 0, 0, 1, OP_ADD), 64'd0);
    run_one("post_rst_imm", mk(0, 0, 29, 1, 12'd9, 1, 1, 0, OP_ADD), 64'd9);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
